// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full flag for the dual-clock FIFO (write clock domain only).
// Define FIFO_WPTR_ALMOST_FULL_EN to build the fill-level counter and the almost_full flag.

`ifdef FIFO_WPTR_ALMOST_FULL_EN
module gray_to_binary #(
    parameter int SIZE = 5
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < SIZE; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule
`endif

module fifo_wptr_full #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2**ADDR_SIZE - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray_async,
    output logic                 wr_accept,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   wr_count
);
    localparam logic [ADDR_SIZE:0] AF_THRESH_W = (ADDR_SIZE+1)'(AF_THRESH);

    logic [ADDR_SIZE:0] wr_bin;
    logic [ADDR_SIZE:0] bin_next;
    logic [ADDR_SIZE:0] gray_next;
    logic [ADDR_SIZE:0] rq_sync_q [SYNC_STAGES];
    logic [ADDR_SIZE:0] rq_sync;
    logic               full_next;

    // Handshake: wr_en is the producer's request; a write happens in any cycle
    // where wr_accept is high, at wr_addr, and the pointer advances on that edge.
    assign wr_accept = wr_en & ~full;
    assign wr_addr   = wr_bin[ADDR_SIZE-1:0];
    assign rq_sync   = rq_sync_q[SYNC_STAGES-1];

    assign bin_next  = wr_bin + {{ADDR_SIZE{1'b0}}, wr_accept};
    assign gray_next = bin_next ^ (bin_next >> 1);

    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    assign full_next = (gray_next == {~rq_sync[ADDR_SIZE:ADDR_SIZE-1], rq_sync[ADDR_SIZE-2:0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
        end else begin
            wr_bin      <= bin_next;
            wr_ptr_gray <= gray_next;
            full        <= full_next;
        end
    end

    // Plain flop chain: the async pointer goes straight into the first stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_sync_q[i] <= '0;
            end
        end else begin
            rq_sync_q[0] <= rd_ptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_sync_q[i] <= rq_sync_q[i-1];
            end
        end
    end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    logic [ADDR_SIZE:0] rd_bin;
    logic [ADDR_SIZE:0] count_next;

    gray_to_binary #(.SIZE(ADDR_SIZE+1)) u_rq_g2b (
        .gray (rq_sync),
        .bin  (rd_bin)
    );

    assign count_next = bin_next - rd_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count    <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_count    <= count_next;
            almost_full <= (count_next >= AF_THRESH_W);
        end
    end
`else
    logic unused_af_thresh;

    assign unused_af_thresh = ^AF_THRESH_W;
    assign wr_count         = '0;
    assign almost_full      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_SIZE=4, SYNC_STAGES=2).
// Almost-full/wr_count checks are added when FIFO_WPTR_ALMOST_FULL_EN is defined.

module tb_fifo_wptr_full;
    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] rd_ptr_gray_async;
    logic       wr_accept;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wptr_full #(.ADDR_SIZE(4), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_en             (wr_en),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .wr_accept         (wr_accept),
        .wr_addr           (wr_addr),
        .wr_ptr_gray       (wr_ptr_gray),
        .full              (full),
        .almost_full       (almost_full),
        .wr_count          (wr_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [4:0] w;
        logic [4:0] prev_g;

        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_ptr_gray_async = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_full", full, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_gray", wr_ptr_gray, 5'b00000);
        check("rst_count", wr_count, 0);
        check("rst_af", almost_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill the FIFO with 16 back-to-back writes, read pointer parked at 0.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            #1;
            check("fill_addr", wr_addr, i);
            check("fill_accept", wr_accept, 1);
            check("fill_full_pre", full, 0);
            tick();
`ifdef FIFO_WPTR_ALMOST_FULL_EN
            if (i == 12) check("af_at_13", almost_full, 0);
            if (i == 13) begin
                check("af_at_14", almost_full, 1);
                check("count_at_14", wr_count, 14);
            end
`endif
        end
        check("full_after_16", full, 1);
        check("gray_after_16", wr_ptr_gray, 5'b11000);
        check("accept_when_full", wr_accept, 0);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        check("count_at_16", wr_count, 16);
`endif

        // Keep pushing while full: nothing may move.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_gray", wr_ptr_gray, 5'b11000);
            check("hold_addr", wr_addr, 0);
            check("hold_accept", wr_accept, 0);
            check("hold_full", full, 1);
        end

        // One read lands in the read domain; full clears after SYNC_STAGES+1 edges.
        wr_en = 1'b0;
        rd_ptr_gray_async = 5'b00001;
        tick();
        check("clr_edge1", full, 1);
        tick();
        check("clr_edge2", full, 1);
        tick();
        check("clr_edge3", full, 0);

        wr_en = 1'b1;
        #1;
        check("refill_accept", wr_accept, 1);
        check("refill_addr", wr_addr, 0);
        tick();
        check("refill_full", full, 1);
        check("refill_gray", wr_ptr_gray, 5'b11001);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        check("refill_count", wr_count, 16);
        check("refill_af", almost_full, 1);
`endif

        // Asynchronous reset in the middle of activity clears everything at once.
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_full", full, 0);
        check("mid_rst_gray", wr_ptr_gray, 0);
        check("mid_rst_addr", wr_addr, 0);
        check("mid_rst_count", wr_count, 0);
        check("mid_rst_af", almost_full, 0);
        wr_en = 1'b0;
        rd_ptr_gray_async = 5'b00000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 64 writes with the read pointer one behind: two full Gray wraps, never full.
        w = 5'd0;
        prev_g = 5'b00000;
        for (int i = 0; i < 64; i++) begin
            rd_ptr_gray_async = to_gray(w - 5'd1);
            wr_en = 1'b1;
            #1;
            check("trk_addr", wr_addr, w[3:0]);
            check("trk_accept", wr_accept, 1);
            tick();
            w = w + 5'd1;
            check("trk_gray", wr_ptr_gray, to_gray(w));
            check("trk_1bit", $countones(wr_ptr_gray ^ prev_g), 1);
            check("trk_full", full, 0);
            check("trk_af", almost_full, 0);
            if (w == 5'd0) check("trk_wrap", prev_g, 5'b10000);
            prev_g = wr_ptr_gray;
        end
        wr_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag stage of the dual-clock FIFO; runs entirely in the write clock domain.
- Advances the binary write pointer and produces the memory write address.
- Publishes the registered Gray write pointer, which the read domain synchronises and then converts back to binary with gray_to_binary.
- Synchronises the incoming read-domain Gray pointer and computes a registered full flag; optionally computes fill level and almost-full via a gray_to_binary instance.

Parameters:
- ADDR_SIZE, 4, address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- SYNC_STAGES, 2, flop stages on the incoming read pointer; legal range 2..4.
- AF_THRESH, 2**ADDR_SIZE-2, fill level at or above which almost_full asserts (optional feature only).

Ports:
- clk  input  1  write-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request from producer.
- rd_ptr_gray_async  input  ADDR_SIZE+1  Gray read pointer from read domain, asynchronous to clk.
- wr_accept  output  1  combinational: wr_en & ~full; the memory write strobe.
- wr_addr  output  ADDR_SIZE  memory write address = low bits of binary write pointer.
- wr_ptr_gray  output  ADDR_SIZE+1  registered Gray write pointer for read-domain sync.
- full  output  1  registered full flag.
- almost_full  output  1  registered; optional feature.
- wr_count  output  ADDR_SIZE+1  registered fill level 0..2**ADDR_SIZE; optional feature.

Behaviour:
- Reset (async assert, sync release): binary pointer, wr_ptr_gray, all sync flops, full, almost_full and wr_count go to 0; wr_addr = 0. Reset mid-operation discards in-flight state with no partial update.
- bin_next = wr_bin + (wr_en & ~full), modulo 2**(ADDR_SIZE+1). gray_next = bin_next ^ (bin_next >> 1). Both are registered each clk.
- wr_addr is wr_bin[ADDR_SIZE-1:0], so it is valid in the same cycle as wr_accept. Data is written at the current address, and the pointer advances on the clock edge.
- Write while full: wr_accept = 0, pointer holds, no overflow, no error flag.
- Synchroniser: plain shift chain of SYNC_STAGES flops; the last stage is rq_sync. No logic before the first flop.
- Full: full_next = (gray_next == {~rq_sync[ADDR_SIZE:ADDR_SIZE-1], rq_sync[ADDR_SIZE-2:0]}). It is registered, so full asserts on the edge of the write that fills the last slot, with no extra cycle of latency.
- Full deassertion: a change on rd_ptr_gray_async reaches rq_sync after SYNC_STAGES edges. full clears on the following edge, so total latency is SYNC_STAGES+1 clk edges. This is pessimistic and never overflows.
- Wrap: the pointer MSB toggles every 2**ADDR_SIZE accepted writes. The Gray sequence wraps 2**(ADDR_SIZE+1)-1 -> 0 with a single-bit change.
- wr_ptr_gray changes by at most one bit per clk. This is a hard requirement.
- Simultaneous wr_en and a read-pointer update: both are applied in the same full_next evaluation, and full reflects both.
- No combinational path from rd_ptr_gray_async to any output.

Optional Feature:
- Macro: FIFO_WPTR_ALMOST_FULL_EN.
- Defined:
  - Instantiate gray_to_binary #(.SIZE(ADDR_SIZE+1)) on rq_sync to get rd_bin.
  - count_next = (bin_next - rd_bin) modulo 2**(ADDR_SIZE+1).
  - wr_count <= count_next.
  - almost_full <= (count_next >= AF_THRESH).
  - Both are registered and share the latency of full.
- Not defined: both ports are still present; wr_count and almost_full are tied to 0; no gray_to_binary instance is built.

Test Plan:
- Reset with rd_ptr_gray_async=0 -> full=0, wr_addr=0, wr_ptr_gray=5'b00000, wr_count=0.
- 16 back-to-back writes, rd pointer held at 0 -> wr_addr steps 0..15; full=1 after 16th edge; wr_ptr_gray=5'b11000; wr_accept=0 thereafter.
- Hold wr_en=1 for 5 more cycles while full -> wr_ptr_gray stays 5'b11000, wr_addr stays 0, no accept.
- From full, set rd_ptr_gray_async=5'b00001 (one read) -> full stays 1 for 2 edges, clears on 3rd (SYNC_STAGES=2). Next write accepted at wr_addr=0 and re-asserts full.
- 64 writes with the read pointer tracking (rd = wr-1, Gray) -> Gray checked for a single-bit change per step through both wraps (5'b10000 -> 5'b00000); full never asserts.
- With FIFO_WPTR_ALMOST_FULL_EN, 14 writes, rd=0 -> almost_full=1 and wr_count=14 after 14th edge, almost_full=0 after 13. Assert rst_n mid-burst -> all outputs 0 immediately.
